// File: rtl/srdl2sv_b2r_arbiter.sv
// Two-requester arbiter in front of a shared srdl2sv register block.
// Round-robin on ties, zero-bubble handover, optional per-beat timeout that answers with err.
package srdl2sv_b2r_pkg;
    typedef struct packed {
        logic        w_vld;
        logic        r_vld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byte_en;
    } b2r_t;

    typedef struct packed {
        logic [31:0] data;
        logic        rdy;
        logic        err;
    } r2b_t;
endpackage

module srdl2sv_b2r_arbiter #(
    parameter int  BUS_BITS       = 32,
    parameter int  TIMEOUT_CYCLES = 255,
    parameter int  COUNT_W        = 8,
    parameter type b2r_t          = srdl2sv_b2r_pkg::b2r_t,
    parameter type r2b_t          = srdl2sv_b2r_pkg::r2b_t
) (
    input  logic HCLK,
    input  logic HRESET,
    input  b2r_t b2r_0,
    output r2b_t r2b_0,
    input  b2r_t b2r_1,
    output r2b_t r2b_1,
    output b2r_t b2r,
    input  r2b_t r2b
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    // TIMEOUT_CYCLES must fit in the counter (<= 2**COUNT_W-1).
    localparam bit                 TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [COUNT_W-1:0] TO_LAST   = COUNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [BUS_BITS-1:0] ZERO_DATA = '0;

    state_t             state, state_nxt;
    logic               last_gnt;
    logic [COUNT_W-1:0] cnt;

    logic req0, req1;
    logic in_gnt, sel, gnt_req, oth_req;
    logic timeout, beat;
    r2b_t rsp;

    assign req0 = b2r_0.w_vld | b2r_0.r_vld;
    assign req1 = b2r_1.w_vld | b2r_1.r_vld;

    always_comb begin
        state_nxt = state;
        b2r       = '0;
        r2b_0     = '0;
        r2b_1     = '0;
        rsp       = r2b;
        in_gnt    = (state == GNT0) || (state == GNT1);
        sel       = (state == GNT1);
        gnt_req   = sel ? req1 : req0;
        oth_req   = sel ? req0 : req1;
        timeout   = TO_EN && in_gnt && gnt_req && !r2b.rdy && (cnt == TO_LAST);
        beat      = in_gnt && gnt_req && (r2b.rdy || timeout);

        if (in_gnt) begin
            b2r = sel ? b2r_1 : b2r_0;
            // A timed-out beat is answered locally and never reaches the block.
            if (timeout) begin
                b2r.w_vld = 1'b0;
                b2r.r_vld = 1'b0;
                rsp.rdy   = 1'b1;
                rsp.err   = 1'b1;
                rsp.data  = ZERO_DATA;
            end
            if (sel) r2b_1 = rsp;
            else     r2b_0 = rsp;
        end

        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = last_gnt ? GNT0 : GNT1;
                else if (req0)    state_nxt = GNT0;
                else if (req1)    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!gnt_req)             state_nxt = IDLE;
                else if (beat && oth_req) state_nxt = sel ? GNT0 : GNT1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (beat) last_gnt <= sel;
            if (beat || !in_gnt || (state_nxt != state))
                cnt <= '0;
            else if (!r2b.rdy && (cnt != CNT_MAX))
                cnt <= cnt + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_srdl2sv_b2r_arbiter.sv
// Directed bench for srdl2sv_b2r_arbiter: grant, tie round-robin, streaming, error, timeout, async reset.
module tb_srdl2sv_b2r_arbiter;
    import srdl2sv_b2r_pkg::*;

    logic HCLK = 1'b0;
    logic HRESET;
    b2r_t b2r_0, b2r_1, b2r;
    r2b_t r2b_0, r2b_1, r2b;

    int checks   = 0;
    int failures = 0;

    srdl2sv_b2r_arbiter #(
        .BUS_BITS(32), .TIMEOUT_CYCLES(4), .COUNT_W(8)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .b2r_0(b2r_0), .r2b_0(r2b_0),
        .b2r_1(b2r_1), .r2b_1(r2b_1),
        .b2r(b2r), .r2b(r2b)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic b2r_t mk(input logic w, input logic r, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be);
        b2r_t t;
        t.w_vld = w; t.r_vld = r; t.addr = a; t.data = d; t.byte_en = be;
        return t;
    endfunction

    function automatic r2b_t rs(input logic [31:0] d, input logic rdy, input logic err);
        r2b_t t;
        t.data = d; t.rdy = rdy; t.err = err;
        return t;
    endfunction

    b2r_t exp_b;

    initial begin
        HRESET = 1'b1;
        b2r_0 = '0; b2r_1 = '0; r2b = '0;
        #2;
        chk("rst_b2r", b2r, 0);
        chk("rst_r2b_0", r2b_0, 0);
        chk("rst_r2b_1", r2b_1, 0);
        tick();
        HRESET = 1'b0;

        // single read from requester 0
        b2r_0 = mk(0, 1, 32'h10, 0, 4'hf);
        #1 chk("rd_idle_b2r", b2r, 0);
        tick();
        chk("rd_gnt0_addr", b2r.addr, 32'h10);
        chk("rd_gnt0_rvld", b2r.r_vld, 1);
        chk("rd_wait_rdy0", r2b_0.rdy, 0);
        chk("rd_r2b_1_a", r2b_1, 0);
        tick();
        r2b = rs(32'hCAFEF00D, 1, 0);
        #1 chk("rd_data", r2b_0.data, 32'hCAFEF00D);
        chk("rd_rdy0", r2b_0.rdy, 1);
        chk("rd_r2b_1_b", r2b_1.rdy, 0);
        tick();
        b2r_0 = '0; r2b = '0;
        #1 chk("rd_drop_r2b_1", r2b_1, 0);
        tick();
        chk("rd_idle_b2r_end", b2r, 0);
        chk("rd_idle_r2b_0", r2b_0, 0);

        // tie after reset: 0, then 1, then 0
        HRESET = 1'b1;
        #2 HRESET = 1'b0;
        b2r_0 = mk(1, 0, 32'h20, 32'h11111111, 4'hf);
        b2r_1 = mk(1, 0, 32'h40, 32'h22222222, 4'h3);
        r2b   = rs(0, 1, 0);
        tick();
        chk("tie_first_addr", b2r.addr, 32'h20);
        chk("tie_first_rdy0", r2b_0.rdy, 1);
        chk("tie_first_rdy1", r2b_1.rdy, 0);
        tick();
        chk("tie_second_addr", b2r.addr, 32'h40);
        chk("tie_second_rdy1", r2b_1.rdy, 1);
        chk("tie_second_rdy0", r2b_0.rdy, 0);
        tick();
        chk("tie_third_addr", b2r.addr, 32'h20);
        b2r_0 = '0; b2r_1 = '0; r2b = '0;
        tick();
        chk("tie_idle_b2r", b2r, 0);

        // requester 1 streams three writes
        b2r_1 = mk(1, 0, 32'h80, 32'hA5A50001, 4'b1010);
        r2b   = rs(0, 1, 0);
        exp_b = b2r_1;
        tick();
        chk("b2b_beat1", b2r, exp_b);
        chk("b2b_rdy1_1", r2b_1.rdy, 1);
        tick();
        b2r_1 = mk(1, 0, 32'h84, 32'hA5A50002, 4'b0101);
        exp_b = b2r_1;
        #1 chk("b2b_beat2", b2r, exp_b);
        tick();
        b2r_1 = mk(1, 0, 32'h88, 32'hA5A50003, 4'b1111);
        exp_b = b2r_1;
        #1 chk("b2b_beat3", b2r, exp_b);
        chk("b2b_r2b_0", r2b_0, 0);
        b2r_1 = '0; r2b = '0;
        tick();
        tick();
        chk("b2b_idle", b2r, 0);

        // downstream error reaches only the granted requester
        b2r_0 = mk(0, 1, 32'h30, 0, 4'hf);
        tick();
        r2b = rs(32'hDEAD0000, 1, 1);
        #1 chk("err_err0", r2b_0.err, 1);
        chk("err_rdy0", r2b_0.rdy, 1);
        chk("err_data0", r2b_0.data, 32'hDEAD0000);
        chk("err_err1", r2b_1.err, 0);
        b2r_0 = '0; r2b = '0;
        tick();
        chk("err_idle", b2r, 0);

        // timeout after 4 cycles without rdy, grant then passes to requester 1
        b2r_0 = mk(1, 0, 32'h50, 32'h12345678, 4'hf);
        r2b   = rs(32'h55, 0, 0);
        tick();
        chk("to_c1_rdy", r2b_0.rdy, 0);
        chk("to_c1_wvld", b2r.w_vld, 1);
        tick();
        tick();
        chk("to_c3_rdy", r2b_0.rdy, 0);
        tick();
        b2r_1 = mk(0, 1, 32'h60, 0, 4'hf);
        #1 chk("to_rdy", r2b_0.rdy, 1);
        chk("to_err", r2b_0.err, 1);
        chk("to_data", r2b_0.data, 0);
        chk("to_wvld", b2r.w_vld, 0);
        chk("to_rvld", b2r.r_vld, 0);
        tick();
        chk("to_release_addr", b2r.addr, 32'h60);
        chk("to_release_rdy0", r2b_0.rdy, 0);
        chk("to_release_rdy1", r2b_1.rdy, 0);
        b2r_0 = '0; b2r_1 = '0;
        tick();

        // asynchronous reset mid-beat in GNT1
        b2r_1 = mk(1, 0, 32'h70, 32'h0BADBEEF, 4'hf);
        r2b   = rs(0, 0, 0);
        tick();
        chk("rst_mid_wvld_pre", b2r.w_vld, 1);
        #2 HRESET = 1'b1;
        #1 chk("rst_mid_b2r", b2r, 0);
        chk("rst_mid_r2b_0", r2b_0, 0);
        chk("rst_mid_r2b_1", r2b_1, 0);
        tick();
        HRESET = 1'b0;
        b2r_0 = mk(0, 1, 32'h90, 0, 4'hf);
        #1 chk("rst_after_idle", b2r, 0);
        tick();
        chk("rst_after_gnt0", b2r.addr, 32'h90);
        chk("rst_after_rdy1", r2b_1.rdy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srdl2sv_b2r_arbiter.md
SRDL2SV_B2R_ARBITER -- requirements
Module: srdl2sv_b2r_arbiter

Interface
REQ-001 Parameter BUS_BITS, default 32: data width of every b2r/r2b port; BUS_BYTES = BUS_BITS/8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a granted beat waits for downstream rdy; 0 disables the timeout.
REQ-003 Parameter COUNT_W, default 8: width of the timeout counter; TIMEOUT_CYCLES SHALL be no greater than 2**COUNT_W-1.
REQ-004 HCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 HRESET  input  1  reset, asynchronous, active-high.
REQ-006 b2r_0  input  b2r_t  requester 0 register request (w_vld, r_vld, addr[31:0], data[BUS_BITS-1:0], byte_en[BUS_BYTES-1:0]).
REQ-007 r2b_0  output  r2b_t  response to requester 0 (data, rdy, err).
REQ-008 b2r_1  input  b2r_t  requester 1 register request.
REQ-009 r2b_1  output  r2b_t  response to requester 1.
REQ-010 b2r  output  b2r_t  request to the shared register block.
REQ-011 r2b  input  r2b_t  response from the shared register block.

Function
REQ-012 Requester N is "requesting" when b2r_N.w_vld or b2r_N.r_vld is 1.
REQ-013 A beat is one cycle with the granted requester requesting and r2b.rdy=1, or a timeout cycle (REQ-021).
REQ-014 The FSM SHALL have states IDLE, GNT0, GNT1; state and last-grant pointer are registered.
REQ-015 IDLE: downstream b2r all fields 0; r2b_0 and r2b_1 all fields 0.
REQ-016 IDLE transitions: one requester requesting -> its GNT state next cycle; both requesting -> GNT of the requester not equal to the last-grant pointer; none -> stay IDLE.
REQ-017 GNTn: b2r equals b2r_n combinationally; r2b_n equals r2b combinationally; the other requester's r2b is all 0 (rdy=0 stalls it).
REQ-018 After a beat in GNTn: other requester requesting -> GNT of the other requester; else requester n still requesting -> stay GNTn; else -> IDLE. The last-grant pointer is set to n on every beat.
REQ-019 Requester n dropping both vld in GNTn without a beat -> IDLE next cycle; no beat is counted, the pointer is unchanged, and the timeout counter clears.
REQ-020 The timeout counter clears on state entry and on every beat, and increments each GNT cycle without r2b.rdy, saturating at 2**COUNT_W-1.
REQ-021 With TIMEOUT_CYCLES>0 and the counter equal to TIMEOUT_CYCLES-1 with r2b.rdy=0: r2b_n SHALL show rdy=1, err=1, data=0 in that cycle, and b2r w_vld/r_vld SHALL be forced to 0 in that cycle; this counts as a beat per REQ-018.
REQ-022 r2b.err with r2b.rdy passes to the granted requester unmodified and is treated as a normal beat.
REQ-023 Arbitration latency: one cycle from request in IDLE to grant; zero bubble on handover between GNT0 and GNT1.

Reset
REQ-024 While HRESET=1: state IDLE, last-grant pointer=1 (requester 0 wins the first tie), timeout counter 0.
REQ-025 During reset all outputs SHALL be 0, including b2r.w_vld, b2r.r_vld, r2b_0.rdy and r2b_1.rdy.
REQ-026 Reset asserted mid-beat aborts the beat without any response; after deassertion arbitration restarts from IDLE.

Verification
REQ-027 Single read: b2r_0.r_vld=1 with addr=0x10 from IDLE, r2b rdy=1 with data=0xCAFEF00D on the second GNT0 cycle -> GNT0 entered one cycle after the request, r2b_0.data=0xCAFEF00D with rdy=1, r2b_1.rdy=0 throughout, then IDLE after requester 0 drops vld.
REQ-028 Tie after reset: both requesters request in the same cycle -> GNT0 first; after one beat -> GNT1 with no idle cycle; after that beat, if both are still requesting -> GNT0.
REQ-029 Back-to-back: requester 1 alone issues 3 write beats with rdy=1 every cycle -> GNT1 held, 3 consecutive b2r.w_vld cycles, byte_en and data forwarded unchanged.
REQ-030 Timeout: TIMEOUT_CYCLES=4 and r2b.rdy held at 0 -> on the 4th GNT cycle r2b_n shows rdy=1, err=1 and b2r.w_vld/r_vld=0, then the grant is released.
REQ-031 Downstream error: r2b.err=1 with rdy=1 -> granted requester sees err=1 and rdy=1; the non-granted requester sees err=0.
REQ-032 Reset mid-beat: HRESET asserted in GNT1 with rdy=0 -> all outputs 0 immediately (asynchronously); after release both requesters request -> GNT0.
